// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one registered writeback port among NUM_UNITS result producers,
// with fixed-priority or round-robin selection and a starvation override.
module wb_port_arbiter #(
  parameter int NUM_UNITS    = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 4,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 8,
  localparam int UW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1,
  localparam int CW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_UNITS-1:0]             unit_done,
  input  logic [NUM_UNITS*ID_WIDTH-1:0]    unit_id,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]  unit_data,
  output logic [NUM_UNITS-1:0]             unit_ack,
  output logic                             wb_valid,
  output logic [ID_WIDTH-1:0]              wb_id,
  output logic [DATA_WIDTH-1:0]            wb_data,
  output logic [UW-1:0]                    wb_unit,
  input  logic                             wb_ready
);
  logic                  load_en, gnt_any, wb_valid_q;
  logic [UW-1:0]         gnt_idx, rr_ptr_q, wb_unit_q;
  logic [UW:0]           rr_sum;
  logic [NUM_UNITS-1:0]  rot, starve;
  logic [ID_WIDTH-1:0]   wb_id_q, sel_id;
  logic [DATA_WIDTH-1:0] wb_data_q, sel_data;
  logic [CW-1:0]         cnt_q [NUM_UNITS];
  logic [CW-1:0]         cnt_d [NUM_UNITS];

  assign load_en  = !wb_valid_q || wb_ready;
  // rot[i] is the request of unit (rr_ptr + i) mod NUM_UNITS
  assign rot      = NUM_UNITS'({unit_done, unit_done} >> rr_ptr_q);
  assign unit_ack = (rst_n && load_en && gnt_any) ? NUM_UNITS'(1) << gnt_idx : '0;
  assign wb_valid = wb_valid_q;
  assign wb_id    = wb_id_q;
  assign wb_data  = wb_data_q;
  assign wb_unit  = wb_unit_q;

  always_comb begin
    gnt_any = |unit_done;
    gnt_idx = '0;
    rr_sum  = '0;
    starve  = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      starve[i] = STARVE_LIMIT > 0 && unit_done[i] && cnt_q[i] == CW'(STARVE_LIMIT);
      if (ARB_MODE == 0 && unit_done[i]) gnt_idx = UW'(i);
      if (ARB_MODE != 0 && rot[i]) rr_sum = {1'b0, rr_ptr_q} + (UW + 1)'(i);
    end
    if (ARB_MODE != 0)
      gnt_idx = rr_sum >= (UW + 1)'(NUM_UNITS) ? UW'(rr_sum - (UW + 1)'(NUM_UNITS)) : UW'(rr_sum);
    for (int i = NUM_UNITS - 1; i >= 0; i--)
      if (starve[i]) gnt_idx = UW'(i);
  end

  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_UNITS; i++)
      if (gnt_idx == UW'(i)) begin
        sel_id   = unit_id[i*ID_WIDTH +: ID_WIDTH];
        sel_data = unit_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_UNITS; i++)
      cnt_d[i] = (!unit_done[i] || unit_ack[i]) ? '0 :
                 cnt_q[i] == CW'(STARVE_LIMIT) ? cnt_q[i] : cnt_q[i] + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_id_q    <= '0;
      wb_data_q  <= '0;
      wb_unit_q  <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      if (load_en) begin
        wb_valid_q <= gnt_any;
        if (gnt_any) begin
          wb_id_q   <= sel_id;
          wb_data_q <= sel_data;
          wb_unit_q <= gnt_idx;
          rr_ptr_q  <= gnt_idx == UW'(NUM_UNITS - 1) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 5: number of units sharing one writeback port; legal range 1..9.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: result width.
REQ-003 SHALL have parameter ID_WIDTH, default 4: instruction ID width, log2 of MAX_IDS.
REQ-004 SHALL have parameter ARB_MODE, default 0: 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-005 SHALL have parameter STARVE_LIMIT, default 8: cycles a pending unit waits before forced grant; 0 disables.
REQ-006 SHALL have ports, clock and reset first: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- unit_done  in  NUM_UNITS  per-unit result pending
- unit_id  in  NUM_UNITS*ID_WIDTH  per-unit instruction ID, packed, unit 0 at LSBs
- unit_data  in  NUM_UNITS*DATA_WIDTH  per-unit result, packed, unit 0 at LSBs
- unit_ack  out  NUM_UNITS  result accepted this cycle, combinational
- wb_valid  out  1  registered writeback valid
- wb_id  out  ID_WIDTH  registered ID
- wb_data  out  DATA_WIDTH  registered result
- wb_unit  out  max(1,$clog2(NUM_UNITS))  index of source unit
- wb_ready  in  1  consumer accepts wb_* this cycle

Function
REQ-007 SHALL define load_en = !wb_valid | wb_ready; arbitration occurs only when load_en = 1.
REQ-008 SHALL assert at most one unit_ack bit per cycle, and only for a unit with unit_done = 1, only when load_en = 1.
REQ-009 SHALL capture the granted unit's id, data and index into wb_id/wb_data/wb_unit and set wb_valid = 1 on the edge following the ack: latency 1 cycle, done to wb_valid.
REQ-010 SHALL clear wb_valid on an edge where load_en = 1 and no unit is granted; wb_id/wb_data/wb_unit hold their values.
REQ-011 SHALL hold wb_valid/wb_id/wb_data/wb_unit stable while wb_valid = 1 and wb_ready = 0.
REQ-012 SHALL require units to hold done/id/data stable until acked; a unit may present a new result on the cycle after its ack.
REQ-013 ARB_MODE 0 SHALL grant the lowest-index requesting unit.
REQ-014 ARB_MODE 1 SHALL keep a pointer rr_ptr; on grant, rr_ptr SHALL become (granted+1) mod NUM_UNITS; search starts at rr_ptr and wraps past NUM_UNITS-1 to 0.
REQ-015 SHALL keep a per-unit wait counter, width $clog2(STARVE_LIMIT+1). It increments each cycle unit_done = 1 and unit_ack = 0, saturates at STARVE_LIMIT, and clears when unit_ack = 1 or unit_done = 0.
REQ-016 If STARVE_LIMIT > 0 and any requesting unit's counter equals STARVE_LIMIT, SHALL grant the lowest-index such unit, overriding REQ-013/014. rr_ptr updates per REQ-014.
REQ-017 While load_en = 0, counters SHALL still increment for pending units.
REQ-018 NUM_UNITS = 1 SHALL degenerate to a single-entry pipeline register; wb_unit SHALL be constant 0.
REQ-019 Throughput SHALL be one result per cycle when wb_ready = 1 continuously.

Reset
REQ-020 rst_n low SHALL immediately force wb_valid = 0, wb_id = 0, wb_data = 0, wb_unit = 0, rr_ptr = 0 and all wait counters = 0, with no clock required.
REQ-021 During reset, unit_ack SHALL be 0. A result held in the output register when reset asserts SHALL be discarded.
REQ-022 The first grant SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-023 Fixed priority, wb_ready = 1. Units 1 and 3 assert done in cycle 0. Required: unit_ack = 5'b00010 in cycle 0 and wb_unit = 1, wb_valid = 1 in cycle 1; unit_ack = 5'b01000 in cycle 1 and wb_unit = 3 in cycle 2; wb_valid = 0 in cycle 3.
REQ-024 Round-robin, all 5 units continuously done, wb_ready = 1. Required: wb_unit sequence 0,1,2,3,4,0,1, one per cycle.
REQ-025 Backpressure. wb_valid = 1 with wb_id = 4'h6, wb_ready = 0 for 3 cycles, unit 2 done. Required: outputs stable, unit_ack = 0 for those 3 cycles. wb_ready = 1 in cycle 4 gives unit_ack[2] = 1 in cycle 4.
REQ-026 Starvation. Fixed priority, STARVE_LIMIT = 4. Unit 0 presents a new result every cycle; unit 2 done from cycle 0. Required: unit 0 acked in cycles 0-3, unit_ack[2] = 1 in cycle 4, unit 0 acked again in cycle 5.
REQ-027 Reset mid-operation. rst_n driven low mid-cycle while wb_valid = 1 and rr_ptr = 3. Required: wb_valid = 0 before the next edge. After release with units 0 and 4 done in round-robin mode, unit 0 is granted first.
REQ-028 The bench SHALL check these assertions every cycle: unit_ack is one-hot-or-zero; unit_ack implies unit_done; and no ack occurs while wb_valid & !wb_ready.
